// File: rtl/gptp_rtc_slew.sv
// gPTP real-time clock (epoch:sec:ns:frac) with set/step/slew/rate commands,
// a registered timestamp capture and a PPS pulse on natural second rollover.
module gptp_rtc_slew #(
  parameter int unsigned      FRAC_W      = 20,
  parameter int unsigned      INC_W       = 26,
  parameter logic [INC_W-1:0] INC_RESET   = 26'h0800000,
  parameter int unsigned      SLEW_MAX_NS = 2,
  parameter int unsigned      PPS_CYCLES  = 16
) (
  input  logic             rtc_clk,
  input  logic             rtc_reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_ns,
  input  logic [31:0]      cmd_sec,
  input  logic [15:0]      cmd_epoch,
  input  logic [INC_W-1:0] cmd_inc,
  input  logic             cap_req,
  output logic             cap_valid,
  output logic [31:0]      cap_nanosec,
  output logic [31:0]      cap_sec,
  output logic [15:0]      cap_epoch,
  output logic [31:0]      rtc_nanosec_field,
  output logic [31:0]      rtc_sec_field,
  output logic [15:0]      rtc_epoch_field,
  output logic             slew_active,
  output logic             pps_out
);

  localparam int unsigned ACC_W = 32 + FRAC_W;
  localparam int unsigned CNT_W = $clog2(PPS_CYCLES + 1);

  localparam logic [31:0]        NS_PER_SEC = 32'd1000000000;
  localparam logic [33:0]        NS_1S_W    = 34'd1000000000;
  localparam logic [33:0]        NS_2S_W    = 34'd2000000000;
  localparam logic signed [31:0] SLEW_POS   = 32'(SLEW_MAX_NS);
  localparam logic signed [31:0] SLEW_NEG   = -SLEW_POS;
  localparam logic [CNT_W-1:0]   PPS_LOAD   = CNT_W'(PPS_CYCLES);

  localparam logic [1:0] OP_SET     = 2'b00;
  localparam logic [1:0] OP_STEP    = 2'b01;
  localparam logic [1:0] OP_SLEW    = 2'b10;
  localparam logic [1:0] OP_SET_INC = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_SLEWING = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         ns_q, ns_d;
  logic [FRAC_W-1:0]   frac_q, frac_d;
  logic [31:0]         sec_q, sec_d;
  logic [15:0]         epoch_q, epoch_d;
  logic [INC_W-1:0]    inc_q, inc_d;
  logic signed [31:0]  rem_q, rem_d;
  logic [CNT_W-1:0]    pps_cnt_q, pps_cnt_d;
  logic                pps_q;
  logic                cap_valid_q;
  logic [31:0]         cap_ns_q, cap_sec_q;
  logic [15:0]         cap_epoch_q;

  logic                cmd_ready_s, slew_active_s, cmd_fire_s;
  logic signed [31:0]  slew_step_s, rem_next_s;
  logic [ACC_W-1:0]    tick_acc_s;
  logic [31:0]         tick_ns_s;
  logic [FRAC_W-1:0]   tick_frac_s;
  logic                tick_roll_s;
  logic [47:0]         tick_secep_s;
  logic [33:0]         step_sum_s;
  logic [31:0]         step_ns_s;
  logic [2:0]          step_adj_s;
  logic [47:0]         step_secep_s;

  assign cmd_fire_s = cmd_valid & cmd_ready_s;

  // Slew correction for this cycle, clamped to the per-cycle limit.
  always_comb begin
    slew_step_s = 32'sd0;
    if (state_q == S_SLEWING) begin
      if (rem_q > SLEW_POS) begin
        slew_step_s = SLEW_POS;
      end else if (rem_q < SLEW_NEG) begin
        slew_step_s = SLEW_NEG;
      end else begin
        slew_step_s = rem_q;
      end
    end else begin
      slew_step_s = 32'sd0;
    end
  end

  assign rem_next_s = rem_q - slew_step_s;

  // A negative slew step wraps modulo 2^ACC_W; the sum stays positive because
  // the integer increment always exceeds the slew limit.
  assign tick_acc_s   = {ns_q, frac_q} + {{(ACC_W-INC_W){1'b0}}, inc_q}
                      + {slew_step_s, {FRAC_W{1'b0}}};
  assign tick_ns_s    = tick_acc_s[ACC_W-1:FRAC_W];
  assign tick_frac_s  = tick_acc_s[FRAC_W-1:0];
  assign tick_roll_s  = (tick_ns_s >= NS_PER_SEC);
  assign tick_secep_s = {epoch_q, sec_q} + 48'd1;

  // STEP: ticked ns plus signed offset, folded back into [0, 1e9) with a second adjust.
  always_comb begin
    step_sum_s = {2'b00, tick_ns_s} + {{2{cmd_ns[31]}}, cmd_ns};
    step_ns_s  = step_sum_s[31:0];
    step_adj_s = 3'd0;
    if (step_sum_s[33]) begin
      step_ns_s  = 32'(step_sum_s + NS_1S_W);
      step_adj_s = 3'b111;
    end else if (step_sum_s >= NS_2S_W) begin
      step_ns_s  = 32'(step_sum_s - NS_2S_W);
      step_adj_s = 3'd2;
    end else if (step_sum_s >= NS_1S_W) begin
      step_ns_s  = 32'(step_sum_s - NS_1S_W);
      step_adj_s = 3'd1;
    end else begin
      step_ns_s  = step_sum_s[31:0];
      step_adj_s = 3'd0;
    end
    step_secep_s = {epoch_q, sec_q} + {{16{cmd_sec[31]}}, cmd_sec}
                 + {{45{step_adj_s[2]}}, step_adj_s};
  end

  // Next value of the time fields, increment, slew residue and PPS counter.
  always_comb begin
    ns_d               = tick_roll_s ? (tick_ns_s - NS_PER_SEC) : tick_ns_s;
    frac_d             = tick_frac_s;
    {epoch_d, sec_d}   = tick_roll_s ? tick_secep_s : {epoch_q, sec_q};
    inc_d              = inc_q;
    rem_d              = 32'sd0;
    if (cmd_fire_s) begin
      case (cmd_op)
        OP_SET: begin
          ns_d    = {2'b00, cmd_ns[29:0]};
          frac_d  = {FRAC_W{1'b0}};
          sec_d   = cmd_sec;
          epoch_d = cmd_epoch;
        end
        OP_STEP: begin
          ns_d             = step_ns_s;
          {epoch_d, sec_d} = step_secep_s;
        end
        OP_SLEW:    rem_d = $signed(cmd_ns);
        OP_SET_INC: inc_d = cmd_inc;
        default:    inc_d = inc_q;
      endcase
    end else if (state_q == S_SLEWING) begin
      rem_d = rem_next_s;
    end else begin
      rem_d = 32'sd0;
    end

    if (cmd_fire_s && ((cmd_op == OP_SET) || (cmd_op == OP_STEP))) begin
      pps_cnt_d = {CNT_W{1'b0}};
    end else if (tick_roll_s) begin
      pps_cnt_d = PPS_LOAD;
    end else if (pps_cnt_q != {CNT_W{1'b0}}) begin
      pps_cnt_d = pps_cnt_q - CNT_W'(1);
    end else begin
      pps_cnt_d = pps_cnt_q;
    end
  end

  // Slew FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire_s && (cmd_op == OP_SLEW) && (cmd_ns != 32'd0)) begin
          state_d = S_SLEWING;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SLEWING: begin
        if (rem_next_s == 32'sd0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SLEWING;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Slew FSM outputs.
  always_comb begin
    cmd_ready_s   = 1'b0;
    slew_active_s = 1'b0;
    case (state_q)
      S_IDLE:    cmd_ready_s   = 1'b1;
      S_SLEWING: slew_active_s = 1'b1;
      default:   cmd_ready_s   = 1'b0;
    endcase
  end

  // Slew FSM state register.
  always_ff @(posedge rtc_clk or negedge rtc_reset) begin
    if (!rtc_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Time, rate, slew residue and PPS registers.
  always_ff @(posedge rtc_clk or negedge rtc_reset) begin
    if (!rtc_reset) begin
      ns_q      <= 32'd0;
      frac_q    <= {FRAC_W{1'b0}};
      sec_q     <= 32'd0;
      epoch_q   <= 16'd0;
      inc_q     <= INC_RESET;
      rem_q     <= 32'sd0;
      pps_cnt_q <= {CNT_W{1'b0}};
      pps_q     <= 1'b0;
    end else begin
      ns_q      <= ns_d;
      frac_q    <= frac_d;
      sec_q     <= sec_d;
      epoch_q   <= epoch_d;
      inc_q     <= inc_d;
      rem_q     <= rem_d;
      pps_cnt_q <= pps_cnt_d;
      pps_q     <= (pps_cnt_d != {CNT_W{1'b0}});
    end
  end

  // Timestamp capture of the pre-update field values.
  always_ff @(posedge rtc_clk or negedge rtc_reset) begin
    if (!rtc_reset) begin
      cap_valid_q <= 1'b0;
      cap_ns_q    <= 32'd0;
      cap_sec_q   <= 32'd0;
      cap_epoch_q <= 16'd0;
    end else begin
      cap_valid_q <= cap_req;
      if (cap_req) begin
        cap_ns_q    <= ns_q;
        cap_sec_q   <= sec_q;
        cap_epoch_q <= epoch_q;
      end
    end
  end

  assign cmd_ready         = cmd_ready_s;
  assign slew_active       = slew_active_s;
  assign pps_out           = pps_q;
  assign cap_valid         = cap_valid_q;
  assign cap_nanosec       = cap_ns_q;
  assign cap_sec           = cap_sec_q;
  assign cap_epoch         = cap_epoch_q;
  assign rtc_nanosec_field = ns_q;
  assign rtc_sec_field     = sec_q;
  assign rtc_epoch_field   = epoch_q;

endmodule
